// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings, the counter
// direction type and the channel-index width helper.
package pwm_pkg;

  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Channel select width; a single channel still gets a 1-bit select.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: counter, direction and the period/mode latched for the
// current frame, plus frame-boundary detection.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] period_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             boundary_o,
  output logic             frame_start_d_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  pwm_dir_e         dir_q, dir_d;
  logic [WIDTH-1:0] act_period_q, act_period_d;
  logic             act_mode_q, act_mode_d;

  logic [WIDTH-1:0] nxt_cnt;
  pwm_dir_e         nxt_dir;
  logic             boundary;
  logic             fs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      act_period_q <= '0;
      act_mode_q   <= PWM_MODE_EDGE;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      act_period_q <= act_period_d;
      act_mode_q   <= act_mode_d;
    end
  end

  // Counter sequencing; ">=" keeps the count bounded even if it ever exceeds P.
  always_comb begin
    nxt_cnt = '0;
    nxt_dir = DIR_UP;
    if (act_mode_q == PWM_MODE_EDGE) begin
      nxt_cnt = (cnt_q >= act_period_q) ? '0 : cnt_q + WIDTH'(1);
      nxt_dir = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= act_period_q) begin
        nxt_cnt = (act_period_q == '0) ? '0 : act_period_q - WIDTH'(1);
        nxt_dir = DIR_DOWN;
      end else begin
        nxt_cnt = cnt_q + WIDTH'(1);
        nxt_dir = DIR_UP;
      end
    end else begin
      nxt_cnt = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
      nxt_dir = DIR_DOWN;
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    act_period_d = act_period_q;
    act_mode_d   = act_mode_q;
    boundary     = 1'b0;
    fs_d         = 1'b0;
    if (!en_i) begin
      // Idle: parked at the frame start, tracking the live period and mode.
      cnt_d        = '0;
      dir_d        = DIR_UP;
      act_period_d = period_i;
      act_mode_d   = mode_i;
    end else begin
      boundary = (nxt_cnt == '0);
      fs_d     = (cnt_q == '0) && (dir_q == DIR_UP);
      cnt_d    = nxt_cnt;
      dir_d    = boundary ? DIR_UP : nxt_dir;
      if (boundary) begin
        act_period_d = period_i;
        act_mode_d   = mode_i;
      end
    end
  end

  assign cnt_o           = cnt_q;
  assign boundary_o      = boundary;
  assign frame_start_d_o = fs_d;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM on one shared timebase with double-buffered duty registers
// that move from shadow to active only at frame boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [WIDTH-1:0]                period,
  input  logic                            mode,
  input  logic                            wr_en,
  input  logic [ch_idx_w(CHANNELS)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]                wr_duty,
  output logic [CHANNELS-1:0]             out,
  output logic                            frame_start
);

  localparam int CW = ch_idx_w(CHANNELS);

  logic [WIDTH-1:0]    cnt;
  logic                boundary;
  logic                fs_d;
  logic                wr_hit;
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0] out_q;
  logic                frame_start_q;

  pwm_timebase #(
    .WIDTH(WIDTH)
  ) u_timebase (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en),
    .period_i       (period),
    .mode_i         (mode),
    .cnt_o          (cnt),
    .boundary_o     (boundary),
    .frame_start_d_o(fs_d)
  );

  // wr_en is a one-cycle strobe with no back-pressure: every in-range write is taken.
  assign wr_hit = wr_en && (int'(wr_ch) < CHANNELS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        if (wr_hit && (wr_ch == CW'(i))) shadow_q <= wr_duty;
        // Transfer reads the pre-write shadow, so a same-edge write waits a frame.
        if (!en || boundary) active_q <= shadow_q;
      end
    end

    assign out_d[i] = en && (active_q > cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      out_q         <= out_d;
      frame_start_q <= en && fs_d;
    end
  end

  assign out         = out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: stimulus pushes per-cycle expected
// {frame_start, out} words tagged with a cycle number; a monitor checks them.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int CW       = ch_idx_w(CHANNELS);
  localparam int OW       = CHANNELS + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [WIDTH-1:0]    period;
  logic                mode;
  logic                wr_en;
  logic [CW-1:0]       wr_ch;
  logic [WIDTH-1:0]    wr_duty;
  logic [CHANNELS-1:0] out;
  logic                frame_start;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] mask_q[$];
  int            cyc_q[$];
  int            tag_q[$];

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int tag    = 0;
  int t0, f0, g0;

  logic [OW-1:0] m_e, m_m, m_o;
  int            m_c, m_t;

  pwm_multi #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .period     (period),
    .mode       (mode),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .out        (out),
    .frame_start(frame_start)
  );

  // Clock and cycle counter: cyc is the number of rising edges so far.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation due at this cycle.
  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      m_c = cyc_q.pop_front();
      m_e = exp_q.pop_front();
      m_m = mask_q.pop_front();
      m_t = tag_q.pop_front();
      m_o = {frame_start, out};
      checks++;
      if (m_c != cyc) begin
        errors++;
        $display("FAIL step%0d stale: due at cycle %0d, reached at %0d", m_t, m_c, cyc);
      end else if ((m_o & m_m) !== (m_e & m_m)) begin
        errors++;
        $display("FAIL step%0d cycle %0d: {frame_start,out} got %b want %b", m_t, cyc, m_o, m_e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_at(input int c, input logic [OW-1:0] e);
    cyc_q.push_back(c);
    exp_q.push_back(e);
    mask_q.push_back('1);
    tag_q.push_back(tag);
  endtask

  task automatic write_duty(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = CW'(ch);
    wr_duty = WIDTH'(d);
    tick(1);
    wr_en   = 1'b0;
  endtask

  // Edge-aligned frames: channel high for the first min(D,P+1) cycles.
  task automatic push_edge(input int start, input int p, input int d0, input int d1,
                           input int d2, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      for (int k = 0; k <= p; k++) begin
        expect_at(start + f * (p + 1) + k, {k == 0, k < d2, k < d1, k < d0});
      end
    end
  endtask

  // Hand-written per-offset patterns (bit k = frame offset k).
  task automatic push_pat(input int start, input int len, input logic [15:0] p0,
                          input logic [15:0] p1, input logic [15:0] p2, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      for (int k = 0; k < len; k++) begin
        expect_at(start + f * len + k, {k == 0, p2[k], p1[k], p0[k]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = PWM_MODE_EDGE; period = '0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0;

    // Reset state
    tick(1);
    tag = 1;
    expect_at(cyc + 1, '0);
    expect_at(cyc + 2, '0);
    tick(3);
    rst = 1'b0;

    // Edge mode, P=9, ch0 D=3
    tag = 2;
    period = 8'd9; mode = PWM_MODE_EDGE;
    write_duty(0, 3);
    tick(1);
    en = 1'b1; t0 = cyc + 1;
    push_edge(t0, 9, 3, 0, 0, 3);
    wait_until(t0 + 29);

    // Extremes at P=9: D=0 low, D=10 and D=255 high
    tag = 3;
    en = 1'b0;
    expect_at(cyc + 1, '0);
    write_duty(0, 0); write_duty(1, 10); write_duty(2, 255);
    tick(1);
    en = 1'b1; t0 = cyc + 1;
    push_edge(t0, 9, 0, 10, 255, 2);
    wait_until(t0 + 19);

    // P=0: every cycle is a frame start
    tag = 4;
    en = 1'b0; period = 8'd0;
    write_duty(0, 1);
    tick(1);
    en = 1'b1; t0 = cyc + 1;
    push_edge(t0, 0, 1, 10, 255, 5);
    wait_until(t0 + 4);

    // Centre mode, P=4, ch1 D=2
    tag = 5;
    en = 1'b0; period = 8'd4; mode = PWM_MODE_CENTER;
    write_duty(0, 0); write_duty(1, 2); write_duty(2, 0);
    tick(1);
    en = 1'b1; t0 = cyc + 1;
    push_pat(t0, 8, 16'h0, 16'b1000_0011, 16'h0, 2);
    wait_until(t0 + 15);

    // Mid-frame write 2->7 at cnt=5, then 7->4 on the boundary edge
    tag = 6;
    en = 1'b0; period = 8'd9; mode = PWM_MODE_EDGE;
    write_duty(1, 0); write_duty(2, 2);
    tick(1);
    en = 1'b1; t0 = cyc + 1;
    push_edge(t0, 9, 0, 0, 2, 1);
    push_edge(t0 + 10, 9, 0, 0, 7, 2);
    push_edge(t0 + 30, 9, 0, 0, 4, 1);
    wait_until(t0 + 4);
    write_duty(2, 7);
    wait_until(t0 + 18);
    write_duty(2, 4);
    wait_until(t0 + 39);

    // Period/mode change mid-frame; out-of-range channel write
    tag = 7;
    f0 = t0 + 40;
    push_edge(f0, 9, 0, 0, 4, 1);
    push_pat(f0 + 10, 8, 16'h0, 16'h0, 16'b1110_1111, 2);
    wait_until(f0 + 3);
    period = 8'd4; mode = PWM_MODE_CENTER;
    wait_until(f0 + 5);
    wr_en = 1'b1; wr_ch = CW'(CHANNELS); wr_duty = 8'd99;
    tick(1);
    wr_en = 1'b0;
    wait_until(f0 + 25);

    // en low mid-frame, then re-enable with a fresh shadow
    tag = 8;
    g0 = f0 + 26;
    push_pat(g0, 3, 16'h0, 16'h0, 16'b1110_1111, 1);
    wait_until(g0 + 2);
    en = 1'b0;
    expect_at(g0 + 3, '0);
    expect_at(g0 + 4, '0);
    write_duty(0, 3);
    tick(1);
    en = 1'b1; t0 = cyc + 1;
    push_pat(t0, 8, 16'b1100_0111, 16'h0, 16'b1110_1111, 1);
    wait_until(t0 + 7);

    // Reset with a concurrent write: all shadows end up 0
    tag = 9;
    rst = 1'b1; wr_en = 1'b1; wr_ch = CW'(1); wr_duty = 8'd50;
    expect_at(cyc + 1, '0);
    tick(1);
    rst = 1'b0; wr_en = 1'b0; en = 1'b0; period = 8'd9; mode = PWM_MODE_EDGE;
    tick(1);
    en = 1'b1; t0 = cyc + 1;
    push_edge(t0, 9, 0, 0, 0, 1);
    wait_until(t0 + 9);

    for (int i = 0; i < 20 && cyc_q.size() > 0; i++) tick(1);
    if (cyc_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", cyc_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator sharing one timebase. Successor to the single-channel 8-bit PWM: adds a programmable period, edge- or centre-aligned counting, per-channel double-buffered duty registers updated glitch-free at frame boundaries, and a frame-start strobe. It sits between a register interface (duty writes) and output pins or gate drivers.

## Interface
- WIDTH, 8: counter, period and duty width.
- CHANNELS, 4: number of independent PWM outputs (1..16).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable; low holds the timebase idle.
- period  in  WIDTH  top count P; sampled only at frame boundaries.
- mode  in  1  0 = edge-aligned, 1 = centre-aligned; sampled only at frame boundaries.
- wr_en  in  1  duty write strobe.
- wr_ch  in  $clog2(CHANNELS) (min 1)  target channel.
- wr_duty  in  WIDTH  duty value D written to the shadow register.
- out  out  CHANNELS  PWM outputs, registered.
- frame_start  out  1  one-cycle pulse marking the first cycle of each frame.

## Operation
- State: cnt (WIDTH), dir (up/down), act_period, act_mode, shadow[CHANNELS], active[CHANNELS].
- Edge mode: cnt runs 0,1,…,P,0. Frame = P+1 cycles.
- Centre mode: cnt runs 0,1,…,P,P-1,…,1,0. Frame = 2P cycles. P=1 gives 0,1,0,1.
- P=0 in either mode: cnt stays 0; every cycle is a frame boundary.
- Compare: out[i] high when active[i] > cnt, strictly. D=0 gives a constant low output. D≥P+1 gives a constant high output.
- High cycles per frame: edge mode, min(D,P+1). Centre mode, 2D-1 for 1≤D≤P.
- Writes: when wr_en is high and wr_ch < CHANNELS, shadow[wr_ch] ← wr_duty. Writes with wr_ch ≥ CHANNELS are ignored. Writes are accepted whether en is high or low.
- Frame boundary: a clock edge where en is high and the next cnt is 0. On that edge active[] ← shadow[], act_period ← period, act_mode ← mode, dir ← up.
- Write on the same edge as a boundary: the transfer uses the pre-write shadow value. The new value takes effect at the following boundary.
- period and mode changes inside a frame do not affect the current frame.
- en low: cnt ← 0, dir ← up, out ← 0, frame_start ← 0. active/act_period/act_mode track shadow/period/mode every cycle, so the first enabled frame uses current values.
- en dropping mid-frame: the frame is abandoned immediately, with no completion.
- rst: cnt=0, dir=up, shadow=0, active=0, act_period=0, act_mode=0, out=0, frame_start=0. rst overrides en and wr_en on the same edge. Reset mid-frame takes effect at the next edge.

## Timing
- On each enabled edge:
  - out[i] ← (active[i] > cnt)
  - frame_start ← (cnt == 0 && dir == up)
  - cnt advances.
- out and frame_start lag cnt by one cycle. Both are asserted together for the first cycle of each frame.
- The first enabled edge after en rises registers the cnt=0 compare. out is valid from the following cycle.
- Duty write to visible output: at most one frame plus one cycle.
- No combinational path from any input to any output.

## Structure
- Shared package pwm_pkg holds:
  - the mode encoding constants PWM_MODE_EDGE=0 and PWM_MODE_CENTER=1;
  - a function for the channel index width (clog2 with a minimum of 1).
- Sub-module pwm_timebase contains cnt, dir, act_period, act_mode and the boundary detect. It outputs cnt, a boundary strobe and frame_start_d.
- pwm_multi instantiates pwm_timebase. It uses a generate loop for shadow/active registers and per-channel comparators.

## Test plan
- Reset, then en=1, P=9, edge mode, ch0 D=3: frames of 10 cycles; out[0] high 3 cycles then low 7; frame_start every 10 cycles, coincident with the out[0] rise.
- Centre mode, P=4, ch1 D=2: 8-cycle frames; out[1] pattern 1,1,0,0,0,0,0,1 with the frame starting at cnt=0 (3 high cycles = 2D-1).
- Extremes with P=9: D=0 gives out low always; D=10 and D=255 give out high always; P=0 gives frame_start high every cycle.
- Mid-frame write: ch2 D=2→7 written at cnt=5. The current frame keeps 2 high cycles; the next frame shows 7. Repeat with the write on the boundary edge: the change appears one frame later.
- Mid-frame changes: change period 9→4 and mode 0→1 mid-frame; the current frame completes at 10 cycles. A write with wr_ch=CHANNELS leaves all shadows unchanged.
- en low mid-frame gives out=0 and cnt=0 on the next edge. Re-enable: the first frame is full and uses current shadows. Assert rst together with wr_en: the shadow stays 0.
